// File: rtl/branch_resolve_ctrl.sv
// Branch resolve sequencer: queues predicted branches in order, checks each
// resolution from execute against its stored prediction, trains the predictor
// and on a mispredict redirects fetch, flushes and drops younger branches.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pred_valid/taken/pc/offset, pred_ready   prediction push interface
//   res_valid, res_taken     resolution of the oldest in-flight branch
//   update_valid/pc/taken    one-cycle predictor training pulse
//   redirect_valid/pc        one-cycle fetch redirect pulse
//   flush                    pipeline flush, held FLUSH_CYCLES cycles
//   inflight_count           occupied queue entries
//   mispredict_count         mispredicts since reset (wraps)
module branch_resolve_ctrl #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned PC_W         = 64,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pred_valid,
    input  logic                         pred_taken,
    input  logic [PC_W-1:0]              pred_pc,
    input  logic [PC_W-1:0]              pred_offset,
    output logic                         pred_ready,
    input  logic                         res_valid,
    input  logic                         res_taken,
    output logic                         update_valid,
    output logic [PC_W-1:0]              update_pc,
    output logic                         update_taken,
    output logic                         redirect_valid,
    output logic [PC_W-1:0]              redirect_pc,
    output logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   inflight_count,
    output logic [15:0]                  mispredict_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned FC_W  = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {ST_RUN, ST_FLUSH} state_e;

    // Queue storage
    logic [PC_W-1:0] mem_pc_q    [DEPTH];
    logic [PC_W-1:0] mem_off_q   [DEPTH];
    logic            mem_taken_q [DEPTH];

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [15:0]       mispredict_count_q, mispredict_count_d;
    logic              update_valid_q, update_valid_d;
    logic [PC_W-1:0]   update_pc_q, update_pc_d;
    logic              update_taken_q, update_taken_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic              flush_q, flush_d;

    logic              push_c, resolve_c, mispredict_c, wr_en_c;
    logic [PC_W-1:0]   head_pc_c, head_off_c;
    logic              head_taken_c;

    // Ready depends on registers only, so a same-cycle pop cannot raise it
    assign pred_ready = (state_q == ST_RUN) && (count_q < CNT_W'(DEPTH));

    assign head_pc_c    = mem_pc_q[head_q];
    assign head_off_c   = mem_off_q[head_q];
    assign head_taken_c = mem_taken_q[head_q];

    assign push_c       = pred_valid && pred_ready;
    assign resolve_c    = res_valid && (state_q == ST_RUN) && (count_q != '0);
    assign mispredict_c = resolve_c && (res_taken != head_taken_c);
    // A push alongside a mispredict is wrong-path and is not stored
    assign wr_en_c      = push_c && !mispredict_c;

    // Next-state, queue bookkeeping and output pulses
    always_comb begin
        state_d            = state_q;
        head_d             = head_q;
        tail_d             = tail_q;
        count_d            = count_q;
        flush_cnt_d        = flush_cnt_q;
        mispredict_count_d = mispredict_count_q;
        update_valid_d     = 1'b0;
        update_pc_d        = update_pc_q;
        update_taken_d     = update_taken_q;
        redirect_valid_d   = 1'b0;
        redirect_pc_d      = redirect_pc_q;

        if (push_c) begin
            tail_d  = tail_q + PTR_W'(1);
            count_d = count_d + CNT_W'(1);
        end
        if (resolve_c) begin
            head_d         = head_q + PTR_W'(1);
            count_d        = count_d - CNT_W'(1);
            update_valid_d = 1'b1;
            update_pc_d    = head_pc_c;
            update_taken_d = res_taken;
        end

        case (state_q)
            ST_RUN: begin
                if (mispredict_c) begin
                    state_d            = ST_FLUSH;
                    flush_cnt_d        = FC_W'(FLUSH_CYCLES);
                    redirect_valid_d   = 1'b1;
                    redirect_pc_d      = res_taken ? (head_pc_c + head_off_c)
                                                   : (head_pc_c + PC_W'(4));
                    mispredict_count_d = mispredict_count_q + 16'd1;
                    tail_d             = tail_q;
                    head_d             = tail_q;
                    count_d            = '0;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q <= FC_W'(1)) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase

        flush_d = (state_d == ST_FLUSH);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_RUN;
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            flush_cnt_q        <= '0;
            mispredict_count_q <= '0;
            update_valid_q     <= 1'b0;
            update_pc_q        <= '0;
            update_taken_q     <= 1'b0;
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            flush_q            <= 1'b0;
        end else begin
            state_q            <= state_d;
            head_q             <= head_d;
            tail_q             <= tail_d;
            count_q            <= count_d;
            flush_cnt_q        <= flush_cnt_d;
            mispredict_count_q <= mispredict_count_d;
            update_valid_q     <= update_valid_d;
            update_pc_q        <= update_pc_d;
            update_taken_q     <= update_taken_d;
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            flush_q            <= flush_d;
        end
    end

    // Queue entry write; contents need no reset since count gates their use
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_pc_q[tail_q]    <= pred_pc;
            mem_off_q[tail_q]   <= pred_offset;
            mem_taken_q[tail_q] <= pred_taken;
        end
    end

    assign update_valid     = update_valid_q;
    assign update_pc        = update_pc_q;
    assign update_taken     = update_taken_q;
    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign flush            = flush_q;
    assign inflight_count   = count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl (DEPTH=4, PC_W=64,
// FLUSH_CYCLES=2). Inputs change 1 time unit after a rising edge; outputs are
// checked at the same point, i.e. in the cycle following the sampling edge.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid, pred_taken;
    logic [63:0] pred_pc, pred_offset;
    logic        pred_ready;
    logic        res_valid, res_taken;
    logic        update_valid, update_taken;
    logic [63:0] update_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        flush;
    logic [2:0]  inflight_count;
    logic [15:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    branch_resolve_ctrl #(.DEPTH(4), .PC_W(64), .FLUSH_CYCLES(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_pc          (pred_pc),
        .pred_offset      (pred_offset),
        .pred_ready       (pred_ready),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .inflight_count   (inflight_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic pt, input logic [63:0] pc,
                         input logic [63:0] off, input logic rv, input logic rt);
        pred_valid  = pv;
        pred_taken  = pt;
        pred_pc     = pc;
        pred_offset = off;
        res_valid   = rv;
        res_taken   = rt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (5) tick();
        rst = 1'b0;
        tick();

        // Reset then idle
        chk("rst_ready",    64'(pred_ready), 64'd1);
        chk("rst_flush",    64'(flush), 64'd0);
        chk("rst_count",    64'(inflight_count), 64'd0);
        chk("rst_mcount",   64'(mispredict_count), 64'd0);
        chk("rst_upd",      64'(update_valid), 64'd0);
        chk("rst_redir",    64'(redirect_valid), 64'd0);

        // Correct not-taken
        drive(1'b1, 1'b0, 64'h1000, 64'h16, 1'b0, 1'b0);
        tick();
        chk("cnt_push_count", 64'(inflight_count), 64'd1);
        chk("cnt_push_noupd", 64'(update_valid), 64'd0);
        drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
        tick();
        idle();
        chk("cnt_upd_valid", 64'(update_valid), 64'd1);
        chk("cnt_upd_pc",    update_pc, 64'h1000);
        chk("cnt_upd_taken", 64'(update_taken), 64'd0);
        chk("cnt_redir",     64'(redirect_valid), 64'd0);
        chk("cnt_flush",     64'(flush), 64'd0);
        chk("cnt_count",     64'(inflight_count), 64'd0);
        tick();
        chk("cnt_upd_once",  64'(update_valid), 64'd0);

        // Mispredict taken
        drive(1'b1, 1'b0, 64'h1000, 64'h16, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1);
        tick();
        idle();
        chk("mpt_redir",     64'(redirect_valid), 64'd1);
        chk("mpt_redir_pc",  redirect_pc, 64'h1016);
        chk("mpt_upd",       64'(update_valid), 64'd1);
        chk("mpt_upd_taken", 64'(update_taken), 64'd1);
        chk("mpt_flush1",    64'(flush), 64'd1);
        chk("mpt_ready1",    64'(pred_ready), 64'd0);
        chk("mpt_mcount",    64'(mispredict_count), 64'd1);
        chk("mpt_count",     64'(inflight_count), 64'd0);
        tick();
        chk("mpt_redir_once", 64'(redirect_valid), 64'd0);
        chk("mpt_flush2",    64'(flush), 64'd1);
        chk("mpt_ready2",    64'(pred_ready), 64'd0);
        tick();
        chk("mpt_flush3",    64'(flush), 64'd0);
        chk("mpt_ready3",    64'(pred_ready), 64'd1);

        // Mispredict not-taken with younger entries and concurrent push
        drive(1'b1, 1'b1, 64'h2000, 64'h40, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 64'h2100, 64'h40, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 64'h2200, 64'h40, 1'b0, 1'b0);
        tick();
        chk("mpn_count3",    64'(inflight_count), 64'd3);
        drive(1'b1, 1'b1, 64'h2300, 64'h40, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
        chk("mpn_redir_pc",  redirect_pc, 64'h2004);
        chk("mpn_redir",     64'(redirect_valid), 64'd1);
        chk("mpn_upd_pc",    update_pc, 64'h2000);
        chk("mpn_count",     64'(inflight_count), 64'd0);
        chk("mpn_mcount",    64'(mispredict_count), 64'd2);
        tick();
        chk("mpn_flushres_upd", 64'(update_valid), 64'd0);
        chk("mpn_flush",     64'(flush), 64'd1);
        tick();
        chk("mpn_flushres_upd2", 64'(update_valid), 64'd0);
        chk("mpn_flush_end", 64'(flush), 64'd0);
        chk("mpn_count_end", 64'(inflight_count), 64'd0);
        tick();
        idle();
        chk("mpn_empty_res", 64'(update_valid), 64'd0);

        // Full queue; pointers wrap since head/tail are not at slot 0 here
        drive(1'b1, 1'b0, 64'h3000, 64'h8, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 64'h3010, 64'h8, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 64'h3020, 64'h8, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 64'h3030, 64'h8, 1'b0, 1'b0);
        tick();
        chk("full_count",    64'(inflight_count), 64'd4);
        chk("full_ready",    64'(pred_ready), 64'd0);
        drive(1'b1, 1'b0, 64'h4000, 64'h8, 1'b0, 1'b0);
        tick();
        chk("full_ignored",  64'(inflight_count), 64'd4);
        drive(1'b1, 1'b0, 64'h4000, 64'h8, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1);
        chk("full_pr_count", 64'(inflight_count), 64'd3);
        chk("full_pr_ready", 64'(pred_ready), 64'd1);
        chk("full_upd0_pc",  update_pc, 64'h3000);
        tick();
        drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
        chk("full_upd1_v",   64'(update_valid), 64'd1);
        chk("full_upd1_pc",  update_pc, 64'h3010);
        tick();
        drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1);
        chk("full_upd2_v",   64'(update_valid), 64'd1);
        chk("full_upd2_pc",  update_pc, 64'h3020);
        tick();
        idle();
        chk("full_upd3_v",   64'(update_valid), 64'd1);
        chk("full_upd3_pc",  update_pc, 64'h3030);
        chk("full_count0",   64'(inflight_count), 64'd0);
        chk("full_no_redir", 64'(redirect_valid), 64'd0);
        chk("full_mcount",   64'(mispredict_count), 64'd2);

        // Reset mid-flush
        drive(1'b1, 1'b0, 64'h5000, 64'h8, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1);
        tick();
        idle();
        chk("rmf_flush",     64'(flush), 64'd1);
        chk("rmf_mcount",    64'(mispredict_count), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmf_flush0",    64'(flush), 64'd0);
        chk("rmf_ready",     64'(pred_ready), 64'd1);
        chk("rmf_count",     64'(inflight_count), 64'd0);
        chk("rmf_mcount0",   64'(mispredict_count), 64'd0);
        chk("rmf_redir",     64'(redirect_valid), 64'd0);
        chk("rmf_upd",       64'(update_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
